max_pool: RTL

Temporal max-pooling stage directly downstream of the quantizer in the wake-word datapath. It consumes the quantizer's 8-bit saturated stream as frames of `NUM_CH` channel words, each frame terminated by `last`. It takes the element-wise signed maximum over `POOL_LEN` consecutive frames and emits one pooled frame per `POOL_LEN` input frames toward the next conv layer's input buffer. Both sides use valid/ready handshakes, and the output is registered.

---
 rtl/wrd_pkg.sv | 13 +
 rtl/max_pool_buf.sv | 33 +++
 rtl/max_pool.sv | 124 ++++++++++++
 3 files changed

// File: rtl/wrd_pkg.sv
// Shared word type and signed-max helper for the wake-word datapath.
package wrd_pkg;

    localparam int WRD_BW = 8;

    typedef logic signed [WRD_BW-1:0] wrd_word_t;

    // Ties keep the first operand, so a buffered value survives an equal input.
    function automatic wrd_word_t smax(input wrd_word_t a, input wrd_word_t b);
        return (b > a) ? b : a;
    endfunction

endpackage

// File: rtl/max_pool_buf.sv
// Per-channel accumulation buffer: NUM_CH words, one write port, one async read port.
// Latency: read is combinational, write lands on the next edge; no backpressure (always writable).
module max_pool_buf #(
    parameter int BW     = 8,
    parameter int NUM_CH = 8,
    parameter int AW     = 3
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [BW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [BW-1:0] rdata_o
);

    logic [BW-1:0] mem_q [NUM_CH];
    logic [BW-1:0] mem_d [NUM_CH];

    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    // Contents are never reset: the first frame of every pool overwrites them.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/max_pool.sv
// Temporal max-pool over POOL_LEN frames of NUM_CH words; 1-cycle latency, registered output.
// Backpressure: ready_o stalls only in the emitting frame while the output register is held.
// Build option MAX_POOL_LAST_CHECK_EN: check last_i against channel count, raise sticky err_o.
module max_pool
    import wrd_pkg::*;
#(
    parameter int BW       = WRD_BW,
    parameter int NUM_CH   = 8,
    parameter int POOL_LEN = 2
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [BW-1:0] data_i,
    input  logic          valid_i,
    input  logic          last_i,
    output logic          ready_o,
    output logic [BW-1:0] data_o,
    output logic          valid_o,
    output logic          last_o,
    input  logic          ready_i,
    output logic          err_o
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FR_W = (POOL_LEN > 1) ? $clog2(POOL_LEN) : 1;
    localparam logic [CH_W-1:0] CH_MAX = CH_W'(NUM_CH - 1);
    localparam logic [FR_W-1:0] FR_MAX = FR_W'(POOL_LEN - 1);

    logic [CH_W-1:0] ch_q, ch_d;
    logic [FR_W-1:0] fr_q, fr_d;
    logic [BW-1:0]   data_q, data_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            err_q, err_d;

    logic            in_xfer, out_xfer, is_emit, ch_last, frame_end, len_err;
    logic            buf_we;
    logic [BW-1:0]   buf_rdata, buf_wdata, pooled;

`ifdef MAX_POOL_LAST_CHECK_EN
    // An early last closes the frame; a missing one is only flagged.
    assign frame_end = ch_last || last_i;
    assign len_err   = (last_i != ch_last);
`else
    logic unused_last;
    assign unused_last = last_i;
    assign frame_end   = ch_last;
    assign len_err     = 1'b0;
`endif

    always_comb begin
        is_emit   = (fr_q == FR_MAX);
        ch_last   = (ch_q == CH_MAX);
        ready_o   = is_emit ? (!valid_q || ready_i) : 1'b1;
        in_xfer   = valid_i && ready_o;
        out_xfer  = valid_q && ready_i;
        pooled    = smax(wrd_word_t'(buf_rdata), wrd_word_t'(data_i));
        buf_we    = in_xfer && !is_emit;
        buf_wdata = (fr_q == '0) ? data_i : pooled;

        ch_d    = ch_q;
        fr_d    = fr_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        err_d   = err_q;

        if (out_xfer) begin
            valid_d = 1'b0;
        end
        if (in_xfer) begin
            err_d = err_q || len_err;
            if (frame_end) begin
                ch_d = '0;
                fr_d = is_emit ? '0 : fr_q + FR_W'(1);
            end else begin
                ch_d = ch_q + CH_W'(1);
            end
            if (is_emit) begin
                // A single-frame pool never fills the buffer, so bypass it.
                data_d  = (POOL_LEN == 1) ? data_i : pooled;
                valid_d = 1'b1;
                last_d  = frame_end;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ch_q    <= '0;
            fr_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ch_q    <= ch_d;
            fr_q    <= fr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    max_pool_buf #(
        .BW     (BW),
        .NUM_CH (NUM_CH),
        .AW     (CH_W)
    ) u_buf (
        .clk_i   (clk_i),
        .we_i    (buf_we),
        .waddr_i (ch_q),
        .wdata_i (buf_wdata),
        .raddr_i (ch_q),
        .rdata_o (buf_rdata)
    );

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign err_o   = err_q;

endmodule
